// File: rtl/logicshifter_pkg.sv
// rtl/logicshifter_pkg.sv - shared state type and default constants for the H2L status receiver
package logicshifter_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } ls_state_t;

    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_DEGLITCH_CYCLES = 4;
    localparam logic [1:0] DEF_FAULT_ACTIVE = 2'b11;

endpackage

// File: rtl/logicshifter_deglitch.sv
// rtl/logicshifter_deglitch.sv - one status bit: two-flop synchronizer, stability counter, filtered register
module logicshifter_deglitch
    import logicshifter_pkg::*;
#(
    parameter int DEGLITCH_CYCLES = DEF_DEGLITCH_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic async_in,
    output logic filt
);

    localparam logic [3:0] CNT_LAST = 4'(DEGLITCH_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [3:0] cnt;
    logic       filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= 4'd0;
            filt_q <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            if (!run) begin
                cnt    <= 4'd0;
                filt_q <= 1'b0;
            end else if (sync2 == filt_q) begin
                cnt <= 4'd0;
            end else if (cnt == CNT_LAST) begin
                // This edge is the DEGLITCH_CYCLES-th consecutive differing sample.
                filt_q <= sync2;
                cnt    <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Gated so status drops on the same edge the FSM leaves RUN.
    assign filt = filt_q & run;

endmodule

// File: rtl/logicshifter_h2l_status_rx.sv
// rtl/logicshifter_h2l_status_rx.sv - enable/settle sequencing, deglitched status and sticky faults for H2L shifters
module logicshifter_h2l_status_rx
    import logicshifter_pkg::*;
#(
    parameter int         SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int         DEGLITCH_CYCLES = DEF_DEGLITCH_CYCLES,
    parameter logic [1:0] FAULT_ACTIVE    = DEF_FAULT_ACTIVE
) (
    input  logic       CELCLK,
    input  logic       CELRST,
    input  logic       enable_req,
    input  logic [1:0] hv_in,
    input  logic       fault_clr,
    output logic       enable_logicshifter,
    output logic       ready,
    output logic [1:0] status,
    output logic [1:0] fault_bits,
    output logic       fault
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    ls_state_t  state;
    ls_state_t  state_next;
    logic [7:0] settle_cnt;
    logic [7:0] settle_cnt_next;
    logic       run;

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            state      <= OFF;
            settle_cnt <= 8'd0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        case (state)
            OFF: begin
                if (enable_req) begin
                    state_next      = SETTLE;
                    settle_cnt_next = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (!enable_req) begin
                    state_next      = OFF;
                    settle_cnt_next = 8'd0;
                end else if (settle_cnt == 8'd0) begin
                    state_next = RUN;
                end else begin
                    settle_cnt_next = settle_cnt - 8'd1;
                end
            end
            RUN: begin
                if (!enable_req) begin
                    state_next = OFF;
                end
            end
            default: begin
                state_next      = OFF;
                settle_cnt_next = 8'd0;
            end
        endcase
    end

    assign run                 = (state == RUN);
    assign ready               = run;
    assign enable_logicshifter = (state != OFF);

    for (genvar i = 0; i < 2; i++) begin : g_bit
        logicshifter_deglitch #(
            .DEGLITCH_CYCLES(DEGLITCH_CYCLES)
        ) u_deglitch (
            .clk     (CELCLK),
            .rst     (CELRST),
            .run     (run),
            .async_in(hv_in[i]),
            .filt    (status[i])
        );
    end

    // A clear is honoured only once the bit is no longer active; set wins.
    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            fault_bits <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (run && (status[i] == FAULT_ACTIVE[i])) begin
                    fault_bits[i] <= 1'b1;
                end else if (fault_clr && (status[i] != FAULT_ACTIVE[i])) begin
                    fault_bits[i] <= 1'b0;
                end
            end
        end
    end

    assign fault = |fault_bits;

endmodule

// File: tb/tb_logicshifter_h2l_status_rx.sv
// tb/tb_logicshifter_h2l_status_rx.sv - table-driven scoreboard bench for logicshifter_h2l_status_rx
module tb_logicshifter_h2l_status_rx;

    logic       CELCLK = 1'b0;
    logic       CELRST;
    logic       enable_req;
    logic [1:0] hv_in;
    logic       fault_clr;
    logic       enable_logicshifter;
    logic       ready;
    logic [1:0] status;
    logic [1:0] fault_bits;
    logic       fault;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] hv;
        logic       clr;
        int         n;
        logic       exp_en;
        logic       exp_rdy;
        logic [1:0] exp_st;
        logic [1:0] exp_fb;
        string      name;
    } vec_t;

    typedef struct {
        logic       en;
        logic       rdy;
        logic [1:0] st;
        logic [1:0] fb;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    logicshifter_h2l_status_rx dut (
        .CELCLK             (CELCLK),
        .CELRST             (CELRST),
        .enable_req         (enable_req),
        .hv_in              (hv_in),
        .fault_clr          (fault_clr),
        .enable_logicshifter(enable_logicshifter),
        .ready              (ready),
        .status             (status),
        .fault_bits         (fault_bits),
        .fault              (fault)
    );

    always #5 CELCLK = ~CELCLK;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic en, input logic [1:0] hv, input logic clr,
                       input int n, input logic e_en, input logic e_rdy,
                       input logic [1:0] e_st, input logic [1:0] e_fb, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.hv = hv; v.clr = clr; v.n = n;
        v.exp_en = e_en; v.exp_rdy = e_rdy; v.exp_st = e_st; v.exp_fb = e_fb; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        CELRST = v.rst; enable_req = v.en; hv_in = v.hv; fault_clr = v.clr;
        for (int k = 0; k < v.n; k++) begin
            if (k == v.n - 1) begin
                e.en = v.exp_en; e.rdy = v.exp_rdy; e.st = v.exp_st; e.fb = v.exp_fb; e.name = v.name;
                sb.push_back(e);
            end
            @(posedge CELCLK);
            #1;
        end
        e = sb.pop_front();
        chk({e.name, ".enable"}, {1'b0, enable_logicshifter}, {1'b0, e.en});
        chk({e.name, ".ready"}, {1'b0, ready}, {1'b0, e.rdy});
        chk({e.name, ".status"}, status, e.st);
        chk({e.name, ".fault_bits"}, fault_bits, e.fb);
        chk({e.name, ".fault"}, {1'b0, fault}, {1'b0, |e.fb});
    endtask

    task automatic tick(input logic en);
        CELRST = 1'b0; enable_req = en; hv_in = 2'b00; fault_clr = 1'b0;
        @(posedge CELCLK);
        #1;
    endtask

    initial begin
        CELRST = 1'b1; enable_req = 1'b0; hv_in = 2'b00; fault_clr = 1'b0;

        //   rst en  hv    clr n   en rdy st    fb
        add(1, 0, 2'b00, 0, 2,  0, 0, 2'b00, 2'b00, "reset");
        add(0, 1, 2'b00, 0, 1,  1, 0, 2'b00, 2'b00, "settle_entry");
        add(0, 1, 2'b00, 0, 15, 1, 0, 2'b00, 2'b00, "settle_edge16");
        add(0, 1, 2'b00, 0, 1,  1, 1, 2'b00, 2'b00, "run_edge17");
        add(0, 1, 2'b01, 0, 5,  1, 1, 2'b00, 2'b00, "dg0_rise_edge4");
        add(0, 1, 2'b01, 0, 1,  1, 1, 2'b01, 2'b00, "dg0_rise_edge5");
        add(0, 1, 2'b01, 0, 1,  1, 1, 2'b01, 2'b01, "fault0_set");
        add(0, 1, 2'b11, 0, 3,  1, 1, 2'b01, 2'b01, "pulse1_on");
        add(0, 1, 2'b01, 0, 6,  1, 1, 2'b01, 2'b01, "pulse1_after");
        add(0, 1, 2'b01, 1, 1,  1, 1, 2'b01, 2'b01, "clr_while_active");
        add(0, 1, 2'b00, 0, 5,  1, 1, 2'b01, 2'b01, "dg0_fall_edge4");
        add(0, 1, 2'b00, 0, 1,  1, 1, 2'b00, 2'b01, "dg0_fall_edge5");
        add(0, 1, 2'b00, 1, 1,  1, 1, 2'b00, 2'b00, "clr_after_fall");
        add(0, 1, 2'b10, 0, 5,  1, 1, 2'b00, 2'b00, "dg1_rise_edge4");
        add(0, 1, 2'b10, 0, 1,  1, 1, 2'b10, 2'b00, "dg1_rise_edge5");
        add(0, 1, 2'b10, 0, 1,  1, 1, 2'b10, 2'b10, "fault1_set");
        add(0, 0, 2'b10, 0, 1,  0, 0, 2'b00, 2'b10, "leave_run_keeps_fault");
        add(0, 1, 2'b10, 0, 17, 1, 1, 2'b00, 2'b10, "rerun");
        add(0, 1, 2'b10, 0, 2,  1, 1, 2'b00, 2'b10, "mid_deglitch");
        add(1, 1, 2'b10, 0, 1,  0, 0, 2'b00, 2'b00, "reset_mid_deglitch");
        add(0, 1, 2'b00, 0, 5,  1, 0, 2'b00, 2'b00, "settle_again");
        add(1, 1, 2'b00, 0, 1,  0, 0, 2'b00, 2'b00, "reset_mid_settle");
        add(1, 0, 2'b00, 0, 1,  0, 0, 2'b00, 2'b00, "hold_reset");

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Abort during SETTLE once the counter has reached 5, then a full restart.
        tick(1'b1);
        chk("abort.entry_enable", {1'b0, enable_logicshifter}, 2'b01);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1);
            chk("abort.settle_ready", {1'b0, ready}, 2'b00);
        end
        chk("abort.settle_enable", {1'b0, enable_logicshifter}, 2'b01);
        tick(1'b0);
        chk("abort.off_enable", {1'b0, enable_logicshifter}, 2'b00);
        chk("abort.off_ready", {1'b0, ready}, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            chk("abort.idle_ready", {1'b0, ready | enable_logicshifter}, 2'b00);
        end
        for (int k = 0; k < 16; k++) begin
            tick(1'b1);
            chk("restart.settle_ready", {1'b0, ready}, 2'b00);
        end
        tick(1'b1);
        chk("restart.run_ready", {1'b0, ready}, 2'b01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/logicshifter_h2l_status_rx.md
LOGICSHIFTER_H2L_STATUS_RX -- requirements
Module: logicshifter_h2l_status_rx

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16: cycles from shifter enable until the returned status is trusted (range 1..255).
REQ-002 The block SHALL have parameter DEGLITCH_CYCLES, default 4: consecutive stable cycles required to accept a status change (range 1..15).
REQ-003 The block SHALL have parameter FAULT_ACTIVE, default 2'b11: per-bit level that indicates a fault.
REQ-004 The block SHALL have port CELCLK, input, 1 bit: the single clock.
REQ-005 The block SHALL have port CELRST, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable_req, input, 1 bit: request to power the high-to-low return path.
REQ-007 The block SHALL have port hv_in, input, 2 bits: asynchronous status outputs of the high-to-low shifters (top switch driver).
REQ-008 The block SHALL have port fault_clr, input, 1 bit: single-cycle request to clear sticky faults.
REQ-009 The block SHALL have port enable_logicshifter, output, 1 bit: enable to the shifter cells.
REQ-010 The block SHALL have port ready, output, 1 bit: status is valid.
REQ-011 The block SHALL have port status, output, 2 bits: deglitched status.
REQ-012 The block SHALL have port fault_bits, output, 2 bits: sticky per-bit faults.
REQ-013 The block SHALL have port fault, output, 1 bit: OR of fault_bits.

Function
REQ-014 The FSM SHALL have three states: OFF, SETTLE and RUN.
REQ-015 In OFF with enable_req=1, the FSM SHALL move to SETTLE and load the settle counter with SETTLE_CYCLES-1.
REQ-016 In SETTLE, enable_logicshifter SHALL be 1; the counter SHALL decrement each cycle, and at 0 the FSM SHALL enter RUN.
REQ-017 In RUN, enable_logicshifter and ready SHALL both be 1.
REQ-018 When enable_req=0 in SETTLE or RUN, the FSM SHALL return to OFF on the next edge, and enable_logicshifter and ready SHALL drop on that same edge.
REQ-019 ready SHALL be 1 only in RUN; enable_logicshifter SHALL be 0 only in OFF.
REQ-020 Each hv_in bit SHALL pass through a two-flop synchronizer that runs in every state.
REQ-021 Deglitch, per bit: a counter SHALL increment while the synchronized value differs from status and clear when they agree; when the count reaches DEGLITCH_CYCLES, status SHALL take the synchronized value and the counter SHALL clear.
REQ-022 Latency: for an hv_in change first sampled at edge 0 and held stable, status SHALL update at edge DEGLITCH_CYCLES+1.
REQ-023 Deglitch SHALL operate only in RUN; outside RUN, status SHALL be forced to 2'b00 and the counters cleared.
REQ-024 A pulse shorter than DEGLITCH_CYCLES synchronized cycles SHALL leave status unchanged.
REQ-025 In RUN, fault_bits[i] SHALL set one edge after status[i]==FAULT_ACTIVE[i], and SHALL remain set until cleared.
REQ-026 fault_clr=1 SHALL clear fault_bits[i] only if status[i]!=FAULT_ACTIVE[i]; when a set and a clear coincide, set SHALL win.
REQ-027 Leaving RUN SHALL NOT clear fault_bits.
REQ-028 fault SHALL be combinational from the fault_bits registers.

Reset
REQ-029 When CELRST=1 at an edge, the block SHALL enter OFF and set enable_logicshifter=0, ready=0, status=2'b00, fault_bits=2'b00, fault=0, and clear all counters and synchronizer flops.
REQ-030 Reset SHALL take priority over every other input, including mid-SETTLE and mid-deglitch.

Structure
REQ-031 Package logicshifter_pkg SHALL hold the state enum {OFF, SETTLE, RUN} and the default SETTLE_CYCLES, DEGLITCH_CYCLES and FAULT_ACTIVE constants.
REQ-032 Sub-module logicshifter_deglitch SHALL implement one bit (synchronizer, counter and filtered register, plus a run input), instantiated twice.

Verification (defaults)
REQ-033 The bench SHALL cover: reset, then enable_req=1 at edge 0 -> enable_logicshifter=1 after edge 1, ready=1 after edge 17.
REQ-034 The bench SHALL cover: in RUN, hv_in[0] 0->1 held -> status[0]=1 five edges after first sample, and fault_bits[0]=1 and fault=1 one edge later.
REQ-035 The bench SHALL cover: in RUN, a 3-cycle high pulse on hv_in[1] -> status and fault remain 0.
REQ-036 The bench SHALL cover: fault_clr while status[0]=1 -> fault_bits[0] stays 1; after status[0] returns to 0, fault_clr -> fault_bits=2'b00.
REQ-037 The bench SHALL cover: enable_req=0 during SETTLE at count 5 -> OFF on the next edge, enable_logicshifter=0, and ready never asserted.
REQ-038 The bench SHALL cover: CELRST=1 during a deglitch count with fault_bits=2'b10 -> all outputs 0 on the next edge.
